// File: rtl/gerador_janela3x3.sv
// 3x3 sliding-window generator feeding the median filter.
// Two line buffers plus a 3x3 register window over a raster stream.
module gerador_janela3x3 #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] E0,
  output logic [DATA_W-1:0] E1,
  output logic [DATA_W-1:0] E2,
  output logic [DATA_W-1:0] E3,
  output logic [DATA_W-1:0] E4,
  output logic [DATA_W-1:0] E5,
  output logic [DATA_W-1:0] E6,
  output logic [DATA_W-1:0] E7,
  output logic [DATA_W-1:0] E8,
  output logic              win_valid,
  output logic              eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     col;
  logic [CW-1:0]     ccol;
  logic [RW-1:0]     row;
  logic [RW-1:0]     crow;
  logic              last_col;
  logic              last_row;
  logic              win_ok;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] w   [9];

  // sof overrides the counters so the pixel lands at (0,0)
  assign ccol     = sof ? '0 : col;
  assign crow     = sof ? '0 : row;
  assign last_col = (ccol == CW'(IMG_W - 1));
  assign last_row = (crow == RW'(IMG_H - 1));
  assign win_ok   = (crow >= RW'(2)) && (ccol >= CW'(2));

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1[ccol] <= lb0[ccol];
      lb0[ccol] <= pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      eof       <= 1'b0;
      for (int i = 0; i < 9; i++) w[i] <= '0;
    end else if (pix_valid) begin
      w[0] <= w[1];
      w[1] <= w[2];
      w[2] <= lb1[ccol];
      w[3] <= w[4];
      w[4] <= w[5];
      w[5] <= lb0[ccol];
      w[6] <= w[7];
      w[7] <= w[8];
      w[8] <= pix_in;
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : crow + 1'b1;
      end else begin
        col <= ccol + 1'b1;
        row <= crow;
      end
      win_valid <= win_ok;
      eof       <= win_ok && last_row && last_col;
    end else begin
      win_valid <= 1'b0;
      eof       <= 1'b0;
    end
  end

  assign E0 = w[0];
  assign E1 = w[1];
  assign E2 = w[2];
  assign E3 = w[3];
  assign E4 = w[4];
  assign E5 = w[5];
  assign E6 = w[6];
  assign E7 = w[7];
  assign E8 = w[8];

endmodule
